eq_band_sequencer: RTL
======================

EQ_BAND_SEQUENCER -- requirements
Module: eq_band_sequencer

Interface
REQ-001 Parameters: none; 8 bands, 16-bit samples, Q4.12 gains fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 x_valid  in  1  input sample offered.
REQ-005 x  in  16  signed input sample.
REQ-006 x_ready  out  1  sequencer accepts sample this cycle.
REQ-007 eng_start  out  1  one-cycle pulse; shared band-filter engine starts one band.
REQ-008 eng_band  out  3  band index for current engine job.
REQ-009 eng_x  out  16  latched sample for engine, stable from ISSUE until done.
REQ-010 eng_done  in  1  engine result valid, single-cycle pulse.
REQ-011 eng_y  in  16  signed band-filter output, valid with eng_done.
REQ-012 g_wr_en  in  1  write shadow gain.
REQ-013 g_wr_addr  in  3  shadow gain index.
REQ-014 g_wr_data  in  16  signed Q4.12 gain.
REQ-015 g_commit  in  1  request shadow-to-active gain transfer.
REQ-016 y_valid  out  1  equalized output valid.
REQ-017 y  out  16  signed equalized output.
REQ-018 y_ready  in  1  downstream accepts y.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, ACC, OUT; one-hot or binary is free.
REQ-021 IDLE: x_ready=1; on x_valid latch x, clear acc, band=0 -> ISSUE.
REQ-022 ISSUE: eng_start=1 for exactly one cycle, eng_band=band -> WAIT.
REQ-023 WAIT: hold until eng_done; capture eng_y -> ACC; eng_done in any state other than WAIT is ignored.
REQ-024 ACC: acc += (eng_y * gain_active[band]) >>> 12 (32-bit product, arithmetic shift, floor); acc is 24-bit signed, no internal overflow possible.
REQ-025 ACC: band==7 -> OUT; otherwise band+1 -> ISSUE.
REQ-026 OUT: y_valid=1, y = acc saturated to [0x8000, 0x7FFF]; y and y_valid held stable until y_ready; on y_valid&y_ready -> IDLE.
REQ-027 x_ready=0 in all states except IDLE; no sample is dropped or double-accepted.
REQ-028 Latency: with engine done D cycles after start (D>=1), sample accept to y_valid = 1 + 8*(D+2) cycles; D=1 gives 25.
REQ-029 Shadow gains: g_wr_en writes shadow[g_wr_addr] in any state.
REQ-030 g_commit sets commit_pending; a second commit while pending has no extra effect.
REQ-031 Pending commit transfers all 8 shadow gains to active on the cycle a sample is accepted, then clears pending; active gains are never changed mid-sample.
REQ-032 g_wr_en and g_commit in the same cycle: the written value is part of the committed set.
REQ-033 g_commit coincident with sample acceptance: transfer occurs for that same sample.

Reset
REQ-034 rst forces IDLE from any state, including mid-WAIT or OUT; in-flight sample discarded.
REQ-035 After reset: x_ready=1, eng_start=0, eng_band=0, eng_x=0, y_valid=0, y=0, busy=0, acc=0, band=0, commit_pending=0.
REQ-036 After reset, shadow and active gains all 0x1000 (unity).
REQ-037 eng_done arriving after a mid-job reset is ignored per REQ-023.

Verification
REQ-038 Unity gains, engine echoes eng_x with D=1, x=0x0100 -> y=0x0800 exactly 25 cycles after acceptance; eng_band sequence 0..7.
REQ-039 Shadow gain[3]=0x0000 written, no commit, x=0x0100 -> y=0x0800; then g_commit, next x=0x0100 -> y=0x0700.
REQ-040 All gains 0x0800 committed, x=0xFFFF -> each term -1 (floor), y=0xFFF8.
REQ-041 Unity gains, x=0x7000 -> acc 0x38000 -> y=0x7FFF; x=0x9000 -> y=0x8000.
REQ-042 y_ready low 10 cycles in OUT -> y/y_valid stable, x_ready=0 throughout, no second eng_start; x_valid held meanwhile is accepted only after handshake.
REQ-043 rst asserted in WAIT of band 4, late eng_done 2 cycles later -> outputs at reset values, no y_valid, next sample processes from band 0 with unity gains.

Source files
------------

// File: rtl/eq_band_sequencer_if.sv
// Signal bundle for the band sequencer: sample input, shared engine handshake,
// shadow-gain programming port, equalized output, and a state debug view.
interface eq_band_sequencer_if;
  logic        x_valid;
  logic [15:0] x;
  logic        x_ready;
  logic        eng_start;
  logic [2:0]  eng_band;
  logic [15:0] eng_x;
  logic        eng_done;
  logic [15:0] eng_y;
  logic        g_wr_en;
  logic [2:0]  g_wr_addr;
  logic [15:0] g_wr_data;
  logic        g_commit;
  logic        y_valid;
  logic [15:0] y;
  logic        y_ready;
  logic        busy;
  logic [2:0]  state_dbg;

  // Valid/ready: a transfer happens on a rising edge where both are high; the
  // source holds its payload stable while valid is high and ready is low.
  modport slave (
    input  x_valid, x, eng_done, eng_y, g_wr_en, g_wr_addr, g_wr_data, g_commit, y_ready,
    output x_ready, eng_start, eng_band, eng_x, y_valid, y, busy, state_dbg
  );

  modport master (
    output x_valid, x, eng_done, eng_y, g_wr_en, g_wr_addr, g_wr_data, g_commit, y_ready,
    input  x_ready, eng_start, eng_band, eng_x, y_valid, y, busy, state_dbg
  );
endinterface

// File: rtl/eq_band_sequencer.sv
// Runs one sample through 8 bands on a shared filter engine, accumulating
// gain-weighted band outputs into a saturated 16-bit result.
module eq_band_sequencer (
  input logic             clk,
  input logic             rst,
  eq_band_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [2:0]         band;
  logic signed [23:0] acc;
  logic signed [15:0] x_q;
  logic signed [15:0] ey_q;
  logic signed [15:0] shadow [8];
  logic signed [15:0] active [8];
  logic signed [15:0] shadow_next [8];
  logic               pending;
  logic               accept;
  logic signed [31:0] prod;
  logic signed [23:0] term;

  assign accept = (state == S_IDLE) && bus.x_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.x_ready   = 1'b0;
    bus.eng_start = 1'b0;
    bus.y_valid   = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        bus.x_ready = 1'b1;
        bus.busy    = 1'b0;
        if (bus.x_valid) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.eng_start = 1'b1;
        state_next    = S_WAIT;
      end
      S_WAIT:  if (bus.eng_done) state_next = S_ACC;
      S_ACC:   state_next = (band == 3'd7) ? S_OUT : S_ISSUE;
      S_OUT: begin
        bus.y_valid = 1'b1;
        if (bus.y_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A write landing in the same cycle as a transfer belongs to the transferred set.
  always_comb begin
    for (int i = 0; i < 8; i++) shadow_next[i] = shadow[i];
    if (bus.g_wr_en) shadow_next[bus.g_wr_addr] = bus.g_wr_data;
  end

  // Floor-scaled Q4.12 term; |acc| stays well under 2^23 for 8 bands.
  assign prod = ey_q * active[band];
  assign term = {{4{prod[31]}}, prod[31:12]};

  always_ff @(posedge clk) begin
    if (rst) begin
      band    <= 3'd0;
      acc     <= 24'sd0;
      x_q     <= 16'sd0;
      ey_q    <= 16'sd0;
      pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 16'sh1000;
        active[i] <= 16'sh1000;
      end
    end else begin
      for (int i = 0; i < 8; i++) shadow[i] <= shadow_next[i];
      if (accept) pending <= 1'b0;
      else if (bus.g_commit) pending <= 1'b1;
      unique case (state)
        S_IDLE: if (accept) begin
          x_q  <= bus.x;
          acc  <= 24'sd0;
          band <= 3'd0;
          if (pending || bus.g_commit)
            for (int i = 0; i < 8; i++) active[i] <= shadow_next[i];
        end
        S_WAIT: if (bus.eng_done) ey_q <= bus.eng_y;
        S_ACC: begin
          acc <= acc + term;
          if (band != 3'd7) band <= band + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (acc > 24'sd32767)       bus.y = 16'h7FFF;
    else if (acc < -24'sd32768) bus.y = 16'h8000;
    else                        bus.y = acc[15:0];
  end

  assign bus.eng_band  = band;
  assign bus.eng_x     = x_q;
  assign bus.state_dbg = state;
endmodule
